// File: rtl/sync_sequencer.sv
// rtl/sync_sequencer.sv - delayed pulse-train trigger sequencer
// Define SYNC_SEQ_CONTINUOUS_EN to make a latched pulse count of 0 free-running.
module sync_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] delay_reg,
  input  logic [15:0] width_reg,
  input  logic [15:0] gap_reg,
  input  logic [7:0]  count_reg,
  output logic        sync_pulse,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [7:0]  shot_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] width_q, width_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  shot_q, shot_d;
  logic        pulse_q, pulse_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic [15:0] w_load;
  logic [15:0] g_load;
  logic        last_shot;
  logic [2:0]  start_target;

  // Zero-length high/low times behave as one cycle.
  assign w_load = (width_q == 16'd0) ? 16'd0 : width_q - 16'd1;
  assign g_load = (gap_q == 16'd0) ? 16'd0 : gap_q - 16'd1;

`ifdef SYNC_SEQ_CONTINUOUS_EN
  assign last_shot    = (count_q != 8'd0) && (shot_q == count_q);
  assign start_target = ST_DELAY;
`else
  assign last_shot    = (shot_q == count_q);
  assign start_target = (count_reg == 8'd0) ? ST_DONE : ST_DELAY;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    gap_d     = gap_q;
    count_d   = count_q;
    shot_d    = shot_q;
    pulse_d   = pulse_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The delay needs no separate latch: the down-counter holds it for the run.
        if (start && !abort) begin
          width_d = width_reg;
          gap_d   = gap_reg;
          count_d = count_reg;
          shot_d  = 8'd0;
          cnt_d   = delay_reg;
          state_d = start_target;
        end
      end
      ST_DELAY, ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          pulse_d   = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = ST_PULSE;
          pulse_d = 1'b1;
          cnt_d   = w_load;
          shot_d  = shot_q + 8'd1;
        end
      end
      ST_PULSE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          pulse_d   = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          pulse_d = 1'b0;
          if (last_shot) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = g_load;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_DELAY) || (state_d == ST_PULSE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      width_q   <= 16'd0;
      gap_q     <= 16'd0;
      count_q   <= 8'd0;
      shot_q    <= 8'd0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
      shot_q    <= shot_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign sync_pulse = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign shot_count = shot_q;

endmodule

// File: tb/tb_sync_sequencer.sv
// tb/tb_sync_sequencer.sv - self-checking bench for sync_sequencer
// Expected waveforms come from closed-form pulse-train arithmetic.
module tb_sync_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] delay_reg;
  logic [15:0] width_reg;
  logic [15:0] gap_reg;
  logic [7:0]  count_reg;
  logic        sync_pulse;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  shot_count;
  logic [11:0] obs;

  int checks = 0;
  int failures = 0;
  int m_d, m_w, m_g, m_n, m_abort;
  bit m_cont;

  sync_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_reg(delay_reg), .width_reg(width_reg), .gap_reg(gap_reg), .count_reg(count_reg),
    .sync_pulse(sync_pulse), .busy(busy), .done(done), .aborted(aborted), .shot_count(shot_count)
  );

  assign obs = {sync_pulse, busy, done, aborted, shot_count};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: k counts edges after the start-sampling edge (k=0).
  function automatic int wq();  return (m_w == 0) ? 1 : m_w; endfunction
  function automatic int gq();  return (m_g == 0) ? 1 : m_g; endfunction
  function automatic int per(); return wq() + gq(); endfunction
  function automatic bit inf_run(); return m_cont && (m_n == 0); endfunction

  function automatic int shots(int k);
    int r;
    if (k < m_d + 1) return 0;
    r = (k - m_d - 1) / per() + 1;
    if (!inf_run() && r > m_n) r = m_n;
    return r % 256;
  endfunction

  function automatic int end_edge();
    return (m_n == 0) ? 0 : m_d + 1 + (m_n - 1) * per() + wq();
  endfunction

  function automatic bit pulse_on(int k);
    int j;
    if (k < m_d + 1) return 1'b0;
    j = k - m_d - 1;
    return (inf_run() || (j / per()) < m_n) && ((j % per()) < wq());
  endfunction

  function automatic bit busy_on(int k);
    return inf_run() || (m_n > 0 && k < end_edge());
  endfunction

  function automatic logic [11:0] model(int k);
    logic [7:0] sh;
    logic pl, bz, dn, ab;
    if (m_abort >= 0 && k >= m_abort) begin
      sh = 8'(shots(m_abort - 1));
      ab = (k == m_abort);
      return {1'b0, 1'b0, 1'b0, ab, sh};
    end
    sh = 8'(shots(k));
    pl = pulse_on(k);
    bz = busy_on(k);
    dn = !inf_run() && (k == end_edge() + 1);
    return {pl, bz, dn, 1'b0, sh};
  endfunction

  task automatic start_run(input int d, input int w, input int g, input int n);
    m_d = d; m_w = w; m_g = g; m_n = n; m_abort = -1;
    delay_reg = 16'(d);
    width_reg = 16'(w);
    gap_reg   = 16'(g);
    count_reg = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1; abort = 1'b0;
    delay_reg = 16'd3; width_reg = 16'd2; gap_reg = 16'd2; count_reg = 8'd1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs, 12'h000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== 12'h000) begin
        failures++;
        $display("FAIL start_abort_idle cyc=%0d got=%h exp=%h", i, obs, 12'h000);
      end
      tick();
    end
  endtask

  task automatic test_single_pulse();
    start_run(5, 3, 2, 1);
    for (int k = 0; k <= 14; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL single_pulse k=%0d got=%h exp=%h", k, obs, model(k));
      end
      tick();
    end
  endtask

  task automatic test_burst();
    start_run(0, 2, 4, 3);
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL burst k=%0d got=%h exp=%h", k, obs, model(k));
      end
      tick();
    end
  endtask

  task automatic test_zero_fields();
    start_run(0, 0, 0, 2);
    for (int k = 0; k <= 8; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL zero_fields k=%0d got=%h exp=%h", k, obs, model(k));
      end
      tick();
    end
  endtask

  task automatic test_abort_gap();
    start_run(1, 2, 3, 4);
    m_abort = 10;
    for (int k = 0; k <= 16; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL abort_gap k=%0d got=%h exp=%h", k, obs, model(k));
      end
      abort = (k == m_abort - 1);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_in_done();
    start_run(0, 1, 1, 1);
    for (int k = 0; k <= 7; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL abort_in_done k=%0d got=%h exp=%h", k, obs, model(k));
      end
      abort = (k == 2) || (k == 3);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_random_retrigger();
    for (int r = 0; r < 8; r++) begin
      int last;
      start_run($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) m_abort = $urandom_range(1, end_edge() - 1);
      last = end_edge() + 3;
      for (int k = 0; k <= last; k++) begin
        checks++;
        if (obs !== model(k)) begin
          failures++;
          $display("FAIL random run=%0d k=%0d got=%h exp=%h", r, k, obs, model(k));
        end
        delay_reg = 16'($urandom_range(0, 9));
        width_reg = 16'($urandom_range(0, 9));
        gap_reg   = 16'($urandom_range(0, 9));
        count_reg = 8'($urandom_range(0, 9));
        start = (busy_on(k) && (m_abort < 0 || k < m_abort)) ? 1'($urandom_range(0, 1)) : 1'b0;
        abort = (m_abort >= 0) && (k == m_abort - 1);
        tick();
      end
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid_pulse();
    start_run(2, 5, 1, 1);
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL rst_mid_pulse k=%0d got=%h exp=%h", k, obs, model(k));
      end
      if (k < 4) tick();
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (sync_pulse !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_drop got=%b%b exp=00", sync_pulse, busy);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 12'h000) begin
      failures++;
      $display("FAIL rst_after_release got=%h exp=%h", obs, 12'h000);
    end
  endtask

  task automatic test_n_zero();
`ifdef SYNC_SEQ_CONTINUOUS_EN
    start_run(0, 1, 1, 0);
    m_abort = 560;
    for (int k = 0; k <= 565; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL n_zero_cont k=%0d got=%h exp=%h", k, obs, model(k));
      end
      abort = (k == m_abort - 1);
      tick();
    end
    abort = 1'b0;
`else
    start_run(3, 2, 2, 0);
    for (int k = 0; k <= 6; k++) begin
      checks++;
      if (obs !== model(k)) begin
        failures++;
        $display("FAIL n_zero k=%0d got=%h exp=%h", k, obs, model(k));
      end
      tick();
    end
`endif
  endtask

  initial begin
`ifdef SYNC_SEQ_CONTINUOUS_EN
    m_cont = 1'b1;
`else
    m_cont = 1'b0;
`endif
    test_reset();
    test_start_abort_idle();
    test_single_pulse();
    test_burst();
    test_zero_fields();
    test_abort_gap();
    test_abort_in_done();
    test_random_retrigger();
    test_reset_mid_pulse();
    test_n_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_sequencer.md
SYNC_SEQUENCER -- requirements
Module: sync_sequencer

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  100 MHz system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled on clk; ignored unless state is IDLE
- abort  in  1  stop request, sampled on clk; honoured in every state
- delay_reg  in  16  initial delay D, in cycles
- width_reg  in  16  pulse high time W, in cycles; 0 is treated as 1
- gap_reg  in  16  low time G between pulses, in cycles; 0 is treated as 1
- count_reg  in  8  number of pulses N
- sync_pulse  out  1  registered trigger output
- busy  out  1  high in DELAY, PULSE and GAP
- done  out  1  one-cycle strobe when a run completes normally
- aborted  out  1  one-cycle strobe when a run is stopped by abort
- shot_count  out  8  pulses issued in the current or most recent run

REQ-002 The block SHALL have no parameters. Its only configuration SHALL be the macro defined under Configuration.

Function
REQ-003 The block SHALL implement an FSM with the states IDLE, DELAY, PULSE, GAP and DONE.
REQ-004 On a clk edge in IDLE with start=1 and abort=0, the block SHALL do all of the following:
- latch D, W, G and N;
- clear shot_count;
- go to DELAY with its 16-bit down-counter loaded with D.
REQ-005 Latched values SHALL NOT change during a run. Register input changes SHALL take effect only at the next start.
REQ-006 In DELAY, the block SHALL decrement the counter while it is nonzero. On the edge where the counter is 0, it SHALL:
- go to PULSE;
- set sync_pulse=1;
- load the counter with W-1.
REQ-007 This SHALL place the first sync_pulse rise exactly D+1 cycles after the start-sampling edge (D=0 gives 1 cycle).
REQ-008 On each entry to PULSE, shot_count SHALL increment by 1 in the same edge that sets sync_pulse.
REQ-009 In PULSE, sync_pulse SHALL stay high for exactly W cycles, with W=0 treated as 1.
REQ-010 When the PULSE counter expires with shot_count < N, the block SHALL go to GAP with sync_pulse=0 and the counter loaded with G-1.
REQ-011 When the PULSE counter expires with shot_count == N, the block SHALL go to DONE with sync_pulse=0.
REQ-012 GAP SHALL hold sync_pulse low for exactly G cycles (G=0 treated as 1) and then re-enter PULSE.
REQ-013 The rising-edge-to-rising-edge period SHALL therefore be W+G cycles.
REQ-014 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE. shot_count SHALL hold its value until the next start.
REQ-015 abort=1 in DELAY, PULSE or GAP SHALL, on that edge, do all of the following:
- force the state to IDLE;
- set sync_pulse=0;
- set aborted=1 for one cycle;
- leave shot_count unchanged.
REQ-016 abort=1 in DONE SHALL complete DONE normally, with done=1 and aborted=0.
REQ-017 If start and abort are both 1 in IDLE, abort SHALL win: the state stays IDLE and no strobe is issued.
REQ-018 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 Without the continuous mode enabled, a start with N=0 SHALL go directly to DONE, with no pulse, shot_count=0 and done asserted one cycle later.
REQ-020 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-021 rst=0 SHALL asynchronously force all of the following:
- state=IDLE;
- sync_pulse=0, busy=0, done=0, aborted=0;
- shot_count=0;
- the counter and all latched values to 0.
REQ-022 Reset asserted mid-run SHALL drop sync_pulse immediately, without waiting for a clock edge.
REQ-023 After reset release, the block SHALL stay in IDLE until the first sampled start.

Configuration
REQ-024 The macro SYNC_SEQ_CONTINUOUS_EN, when defined, SHALL make a latched N=0 mean free-running operation:
- the PULSE/GAP cycle repeats indefinitely until abort or reset;
- DONE is never entered;
- shot_count wraps from 255 to 0.
REQ-025 When SYNC_SEQ_CONTINUOUS_EN is undefined, N=0 SHALL behave as in REQ-019 and no continuous-mode logic SHALL be synthesised.
REQ-026 Behaviour for N>=1 SHALL be identical with and without the macro.

Verification
REQ-027 Single pulse: D=5, W=3, G=2, N=1, start at edge 0 -> sync_pulse high on edges 6-8, done=1 at edge 10, shot_count=1.
REQ-028 Burst: D=0, W=2, G=4, N=3 -> sync_pulse rises at edges 1, 7 and 13, each high 2 cycles; done once; shot_count=3.
REQ-029 Zero fields: D=0, W=0, G=0, N=2 -> pulses 1 cycle wide, 1 cycle apart; shot_count=2.
REQ-030 Abort and start edge cases:
- abort during the second GAP of N=4 -> aborted strobe, sync_pulse=0, shot_count=2, no done;
- start and abort together in IDLE -> stays IDLE, no strobe.
REQ-031 Re-trigger and reset:
- start pulsed while busy and delay_reg changed mid-run -> timing unchanged;
- rst asserted mid-PULSE -> sync_pulse low before the next edge.
REQ-032 N=0 handling:
- without SYNC_SEQ_CONTINUOUS_EN -> no pulse, done after 1 cycle;
- with SYNC_SEQ_CONTINUOUS_EN -> pulses continue past 256, shot_count wraps to 0, abort stops them.
